// File: rtl/ppm_frame_encoder.sv
// Multi-channel PPM frame encoder: a sync slot, then NUM_CH slots of 2**POS_W ticks, one pulse per slot.
// Define PPM_SYNC_PULSE_EN to also emit a PULSE_W-tick marker pulse at the start of the sync slot.
module ppm_frame_encoder #(
  parameter  int NUM_CH     = 4,
  parameter  int POS_W      = 8,
  parameter  int PRESC      = 1,
  parameter  int PULSE_W    = 2,
  parameter  int SYNC_TICKS = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [POS_W-1:0] wr_data,
  output logic             ppm_out,
  output logic             frame_start,
  output logic [CH_W-1:0]  ch_active,
  output logic             busy
);

  // state | meaning
  // IDLE  | no frame in progress, waiting for en
  // SYNC  | sync slot of SYNC_TICKS ticks at the head of a frame
  // SLOT  | channel slot ch_q, 2**POS_W ticks long
  typedef enum logic [1:0] {IDLE, SYNC, SLOT} state_t;

  localparam int SLOT_TICKS = 2**POS_W;
  localparam int SYNC_BITS  = (SYNC_TICKS > 1) ? $clog2(SYNC_TICKS) : 1;
  localparam int TICK_W     = (POS_W > SYNC_BITS) ? POS_W : SYNC_BITS;
  localparam int PS_W       = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int CMP_W      = TICK_W + 2;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [PS_W-1:0]    presc_q, presc_d;
  logic [POS_W-1:0]   shadow_q [NUM_CH];
  logic [POS_W-1:0]   active_q [NUM_CH];
  logic [POS_W-1:0]   active_d [NUM_CH];
  logic               ppm_q, ppm_d;
  logic               fs_q, fs_d;
  logic               busy_q, busy_d;
  logic [CH_W-1:0]    cha_q, cha_d;
  logic [POS_W-1:0]   cur_v;
  logic               tick_en;
  logic               start_frame;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      tick_q  <= '0;
      presc_q <= '0;
      ppm_q   <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      cha_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      tick_q  <= tick_d;
      presc_q <= presc_d;
      ppm_q   <= ppm_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
      cha_q   <= cha_d;
      for (int i = 0; i < NUM_CH; i++) begin
        active_q[i] <= active_d[i];
        // Indices >= NUM_CH match no entry and are dropped.
        if (wr_en && wr_ch == CH_W'(i)) shadow_q[i] <= wr_data;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    tick_d      = tick_q;
    presc_d     = presc_q;
    active_d    = active_q;
    start_frame = 1'b0;
    tick_en     = (presc_q == '0);

    if (state_q != IDLE) presc_d = tick_en ? PS_W'(PRESC - 1) : presc_q - PS_W'(1);

    case (state_q)
      IDLE: if (en) start_frame = 1'b1;
      SYNC: if (tick_en) begin
        if (tick_q == TICK_W'(SYNC_TICKS - 1)) begin
          state_d = SLOT;
          tick_d  = '0;
          ch_d    = '0;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      SLOT: if (tick_en) begin
        if (tick_q == TICK_W'(SLOT_TICKS - 1)) begin
          tick_d = '0;
          if (ch_q == CH_W'(NUM_CH - 1)) begin
            ch_d = '0;
            if (en) start_frame = 1'b1;
            else begin
              state_d = IDLE;
              presc_d = '0;
            end
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Position counters describe the cycle being registered, so active[] loads on the same edge.
    if (start_frame) begin
      state_d  = SYNC;
      ch_d     = '0;
      tick_d   = '0;
      presc_d  = PS_W'(PRESC - 1);
      active_d = shadow_q;
    end

    cur_v = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_d == CH_W'(i)) cur_v = active_d[i];

    ppm_d = 1'b0;
    case (state_d)
      SLOT: ppm_d = ({2'b00, tick_d} >= CMP_W'(cur_v)) &&
                    ({2'b00, tick_d} <  CMP_W'(cur_v) + CMP_W'(PULSE_W));
      SYNC: begin
`ifdef PPM_SYNC_PULSE_EN
        ppm_d = ({2'b00, tick_d} < CMP_W'(PULSE_W));
`else
        ppm_d = 1'b0;
`endif
      end
      default: ppm_d = 1'b0;
    endcase

    fs_d   = start_frame;
    busy_d = (state_d != IDLE);
    cha_d  = (state_d == SLOT) ? ch_d : '0;
  end

  assign ppm_out     = ppm_q;
  assign frame_start = fs_q;
  assign ch_active   = cha_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ppm_frame_encoder.sv
// Scoreboard bench for ppm_frame_encoder (NUM_CH=2, POS_W=4, SYNC_TICKS=8 -> 40-cycle frames).
module tb_ppm_frame_encoder;

  localparam int F = 40;

  logic       clk = 1'b0;
  logic       rst_n, en, wr_en;
  logic [0:0] wr_ch;
  logic [3:0] wr_data;
  logic       ppm_out, frame_start, busy;
  logic [0:0] ch_active;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit mon_en = 1'b1;

  typedef struct {
    string       name;
    logic [39:0] ppm;
    bit          gap;
  } exp_t;
  exp_t exp_q[$];

  ppm_frame_encoder #(.NUM_CH(2), .POS_W(4), .PRESC(1), .PULSE_W(2), .SYNC_TICKS(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .ppm_out(ppm_out), .frame_start(frame_start), .ch_active(ch_active), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Frame-relative pulse cycles, -1 = unused.
  function automatic logic [39:0] pm(input int a, input int b, input int c, input int d);
    logic [39:0] m = '0;
    if (a >= 0) m[a] = 1'b1;
    if (b >= 0) m[b] = 1'b1;
    if (c >= 0) m[c] = 1'b1;
    if (d >= 0) m[d] = 1'b1;
`ifdef PPM_SYNC_PULSE_EN
    m[0] = 1'b1;
    m[1] = 1'b1;
`endif
    return m;
  endfunction

  task automatic push(input string nm, input logic [39:0] m, input bit gap);
    exp_t e;
    e.name = nm;
    e.ppm  = m;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [0:0] ch, input logic [3:0] d);
    wr_en = 1'b1; wr_ch = ch; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_fs(input string nm);
    bit got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (frame_start) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: frame_start not seen within 100 cycles", nm);
    end
  endtask

  // Monitor: each frame_start presents a 40-cycle frame, compared against the next expectation.
  initial begin
    logic [39:0] ppm_m, fs_m, busy_m, cha_m;
    int start_c;
    int last_end = -10;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en && frame_start) begin
        start_c = cyc;
        for (int i = 0; i < F; i++) begin
          if (i > 0) @(negedge clk);
          ppm_m[i]  = ppm_out;
          fs_m[i]   = frame_start;
          busy_m[i] = busy;
          cha_m[i]  = ch_active[0];
        end
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_frame: frame at cycle %0d with no expectation", start_c);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_ppm"}, 64'(ppm_m), 64'(e.ppm));
          chk({e.name, "_frame_start"}, 64'(fs_m), 64'h1);
          chk({e.name, "_busy"}, 64'(busy_m), 64'hFF_FFFF_FFFF);
          chk({e.name, "_ch_active"}, 64'(cha_m), 64'hFF_FF00_0000);
          if (e.gap) chk({e.name, "_back_to_back"}, 64'(start_c), 64'(last_end + 1));
        end
        last_end = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi_ppm, hi_busy, hi_fs;
    rst_n = 1'b0; en = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ppm_out", 64'(ppm_out), 64'h0);
    chk("rst_frame_start", 64'(frame_start), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_ch_active", 64'(ch_active), 64'h0);
    rst_n = 1'b1; en = 1'b0;
    @(negedge clk);

    // Frames 1-3 back to back; ch0 rewritten to 0 in cycle 0 of frame 2 only affects frame 3.
    wr(1'b0, 4'd3);
    wr(1'b1, 4'd15);
    push("frame1", pm(11, 12, 39, -1), 1'b0);
    push("frame2", pm(11, 12, 39, -1), 1'b1);
    en = 1'b1;
    wait_fs("frame1_start");
    repeat (F) @(negedge clk);
    wr(1'b0, 4'd0);
    push("frame3", pm(8, 9, 39, -1), 1'b1);
    repeat (59) @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    chk("drop_busy_at_F", 64'(busy), 64'h0);
    chk("drop_no_restart", 64'(frame_start), 64'h0);
    hi_ppm = 0; hi_busy = 0; hi_fs = 0;
    repeat (60) begin
      @(negedge clk);
      if (ppm_out) hi_ppm++;
      if (busy) hi_busy++;
      if (frame_start) hi_fs++;
    end
    chk("idle_ppm_cycles", 64'(hi_ppm), 64'h0);
    chk("idle_busy_cycles", 64'(hi_busy), 64'h0);
    chk("idle_frame_starts", 64'(hi_fs), 64'h0);

    // Single frame from IDLE, both pulses near slot ends.
    wr(1'b0, 4'd15);
    wr(1'b1, 4'd14);
    push("frame_c", pm(23, 38, 39, -1), 1'b0);
    en = 1'b1;
    @(negedge clk);
    chk("start_latency", 64'(frame_start), 64'h1);
    en = 1'b0;
    repeat (45) @(negedge clk);

    // Reset in the middle of the ch0 pulse.
    mon_en = 1'b0;
    wr(1'b0, 4'd3);
    wr(1'b1, 4'd15);
    en = 1'b1;
    wait_fs("abort_start");
    en = 1'b0;
    repeat (11) @(negedge clk);
    chk("abort_pulse_before", 64'(ppm_out), 64'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ppm_out", 64'(ppm_out), 64'h0);
    chk("abort_busy", 64'(busy), 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_idle", 64'(busy), 64'h0);

    // Shadow cleared by reset: both channels pulse at slot start.
    mon_en = 1'b1;
    push("frame_d", pm(8, 9, 24, 25), 1'b0);
    en = 1'b1;
    wait_fs("frame_d_start");
    en = 1'b0;
    repeat (45) @(negedge clk);
    chk("pending_expectations", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
